// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// Shared by the arbiter top and anything that inspects its state.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    typedef enum logic {
        FETCH,
        DATA
    } owner_t;

    function automatic owner_t owner_of(arb_state_t s);
        return (s == BUSY_D) ? DATA : FETCH;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between instruction fetch and MEM stage.
// Data wins by default; a saturating counter forces fetch through.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic [WORD_W-1:0] i_rdata,
    output logic              i_valid,
    output logic              i_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,

    output logic              m_req,
    output logic              m_we,
    output logic [WORD_W-1:0] m_addr,
    output logic [WORD_W-1:0] m_wdata,
    input  logic [WORD_W-1:0] m_rdata,
    input  logic              m_ack
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          grant_d;
    logic          grant_i;
    logic          done;
    owner_t        owner;

    assign i_stall = i_req && !i_valid;
    assign d_stall = d_req && !d_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        done     = 1'b0;
        owner    = owner_of(state_q);
        unique case (state_q)
            IDLE: begin
                // Fetch only preempts data once the counter has saturated.
                if (d_req && !(i_req && starve_q == SMAX)) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                    if (!i_req) begin
                        starve_d = '0;
                    end else if (starve_q != SMAX) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (i_req) begin
                    grant_i  = 1'b1;
                    state_d  = BUSY_I;
                    starve_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ack) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_valid <= 1'b0;
            d_valid <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            if (grant_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (grant_i) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= i_addr;
                m_wdata <= '0;
            end else if (done) begin
                m_req <= 1'b0;
                unique case (owner)
                    FETCH: begin
                        i_rdata <= m_rdata;
                        i_valid <= 1'b1;
                    end
                    DATA: begin
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                        d_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        i_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    bit mem_en = 1'b1;
    bit stray_ack = 1'b0;
    int fix_lat = 1;
    int mcnt = 0;
    int mlat = 1;

    typedef struct {
        logic        ir;
        logic        dr;
        logic        dwe;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        int          lat;
        logic        exp_data;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(int i);
        return (i == 16) ? 32'h2402000A : (32'hC0DE0000 | 32'(i));
    endfunction

    // Memory responder: ack arrives mlat cycles after m_req rises.
    task automatic mem_update();
        if (stray_ack) begin
            stray_ack = 1'b0;
            m_ack = 1'b1;
            m_rdata = 32'h5A5A5A5A;
            mcnt = 0;
        end else if (m_req && mem_en) begin
            mcnt++;
            if (mcnt == 1)
                mlat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
            if (mcnt == mlat + 1) begin
                m_ack = 1'b1;
                m_rdata = mem[m_addr[7:2]];
                if (m_we) mem[m_addr[7:2]] = m_wdata;
            end else begin
                m_ack = 1'b0;
                m_rdata = $urandom;
            end
        end else begin
            m_ack = 1'b0;
            mcnt = 0;
            m_rdata = $urandom;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_update();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [5:0] w;
        w = 6'($urandom);
        return {24'h0, w, 2'b00};
    endfunction

    initial begin
        logic [31:0] last_d;
        int dgrants;
        bit fgrant;
        bit prev;
        int pulses;
        bit mbusy;
        owner_t mown;
        logic [31:0] e_addr, e_wdata, e_ird, e_drd;
        logic e_we, e_mreq, e_iv, e_dv;
        int mstarve, iw, dw;
        bit abort;

        for (int i = 0; i < 64; i++) mem[i] = init_val(i);
        tbl[0] = '{1, 0, 0, 32'h40, 0, 0, 2, 0, 32'h40, 0, 32'h2402000A};
        tbl[1] = '{0, 1, 0, 0, 32'h100, 0, 1, 1, 32'h100, 0, 32'hC0DE0000};
        tbl[2] = '{0, 1, 1, 0, 32'h100, 32'hDEADBEEF, 3, 1, 32'h100, 1, 0};
        tbl[3] = '{0, 1, 0, 0, 32'h100, 0, 1, 1, 32'h100, 0, 32'hDEADBEEF};
        tbl[4] = '{1, 1, 0, 32'h48, 32'h4C, 0, 2, 1, 32'h4C, 0, 32'hC0DE0013};
        tbl[5] = '{1, 0, 0, 32'h48, 0, 0, 1, 0, 32'h48, 0, 32'hC0DE0012};
        tbl[6] = '{1, 1, 1, 32'h50, 32'h54, 32'h12345678, 4, 1, 32'h54, 1, 0};
        tbl[7] = '{0, 1, 0, 0, 32'h54, 0, 2, 1, 32'h54, 0, 32'h12345678};

        // Reset state
        #1 reset = 1'b1;
        tick();
        chk1("rst_m_req", m_req, 0);
        chk1("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk1("rst_i_valid", i_valid, 0);
        chk1("rst_d_valid", d_valid, 0);
        chk1("rst_i_stall", i_stall, 0);
        chk1("rst_d_stall", d_stall, 0);
        reset = 1'b0;
        last_d = '0;

        // Vector table: one transaction from IDLE each
        for (int k = 0; k < 8; k++) begin
            vec_t v;
            int w;
            bit seen;
            v = tbl[k];
            tick();
            i_req = v.ir; i_addr = v.ia;
            d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
            fix_lat = v.lat;
            tick();
            chk1("grant_mreq", m_req, 1);
            chk("grant_addr", m_addr, v.exp_addr);
            chk1("grant_we", m_we, v.exp_we);
            if (v.exp_we) chk("grant_wdata", m_wdata, v.dwd);
            if (v.ir && v.dr) chk1("conflict_istall", i_stall, 1);
            w = 0;
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                w++;
                if (v.exp_data ? d_valid : i_valid) begin
                    seen = 1;
                end else begin
                    chk1("hold_mreq", m_req, 1);
                    chk("hold_addr", m_addr, v.exp_addr);
                    chk1("hold_we", m_we, v.exp_we);
                end
            end
            chk1("vec_done", seen, 1);
            chk("vec_latency", 32'(w), 32'(v.lat + 1));
            if (v.exp_data) begin
                chk("vec_d_rdata", d_rdata, v.exp_we ? last_d : v.exp_rdata);
                chk1("vec_d_stall", d_stall, 0);
                chk1("vec_i_valid_quiet", i_valid, 0);
                chk1("vec_loser_stall", i_stall, v.ir);
                if (!v.exp_we) last_d = v.exp_rdata;
            end else begin
                chk("vec_i_rdata", i_rdata, v.exp_rdata);
                chk1("vec_i_stall", i_stall, 0);
                chk1("vec_d_valid_quiet", d_valid, 0);
            end
            chk1("vec_mreq_drop", m_req, 0);
            i_req = 0;
            d_req = 0;
            tick();
            chk1("vec_no_repulse_i", i_valid, 0);
            chk1("vec_no_repulse_d", d_valid, 0);
            chk1("vec_idle_mreq", m_req, 0);
        end

        // Starvation: data held continuously, fetch waiting
        tick();
        i_req = 1; i_addr = 32'h80;
        d_req = 1; d_we = 0; d_addr = 32'h20;
        fix_lat = 1;
        dgrants = 0;
        fgrant = 0;
        prev = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (!fgrant) chk1("starve_istall", i_stall, 1);
            if (m_req && !prev) begin
                if (m_addr == 32'h20) dgrants++;
                if (m_addr == 32'h80) begin
                    fgrant = 1;
                    chk("starve_dgrants", 32'(dgrants), 32'(SMAX));
                    chk("starve_cleared", 32'(dut.starve_q), 0);
                end
            end
            prev = m_req;
            if (i_valid) begin
                chk("starve_i_rdata", i_rdata, 32'hC0DE0020);
                i_req = 0;
                d_req = 0;
                break;
            end
        end
        chk1("starve_fetch_granted", fgrant, 1);

        // Async reset while BUSY_D waits on an ack that never comes
        tick();
        mem_en = 0;
        d_req = 1; d_we = 1; d_addr = 32'h60; d_wdata = 32'hCAFEF00D;
        tick();
        tick();
        chk1("busy_d_mreq", m_req, 1);
        chk1("busy_d_we", m_we, 1);
        #2 reset = 1'b1;
        #1;
        chk1("arst_m_req", m_req, 0);
        chk1("arst_m_we", m_we, 0);
        chk("arst_m_addr", m_addr, 0);
        chk("arst_m_wdata", m_wdata, 0);
        chk("arst_i_rdata", i_rdata, 0);
        chk("arst_d_rdata", d_rdata, 0);
        chk1("arst_i_valid", i_valid, 0);
        chk1("arst_d_valid", d_valid, 0);
        tick();
        reset = 1'b0;
        d_req = 0;
        mem_en = 1;
        fix_lat = 1;
        i_req = 1; i_addr = 32'h44;
        tick();
        chk1("post_rst_mreq", m_req, 1);
        chk("post_rst_addr", m_addr, 32'h44);
        chk1("post_rst_we", m_we, 0);
        pulses = 0;
        for (int c = 0; c < 10 && pulses == 0; c++) begin
            tick();
            if (i_valid) begin
                pulses++;
                chk("post_rst_i_rdata", i_rdata, 32'hC0DE0011);
                i_req = 0;
            end
        end
        chk("post_rst_done", 32'(pulses), 1);
        tick();
        stray_ack = 1;
        tick();
        tick();
        chk1("stray_i_valid", i_valid, 0);
        chk1("stray_d_valid", d_valid, 0);
        chk1("stray_mreq", m_req, 0);

        // Data requester drops d_req and scribbles its address after grant
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h0C;
        fix_lat = 2;
        tick();
        chk1("drop_grant", m_req, 1);
        chk("drop_addr", m_addr, 32'h0C);
        d_req = 0;
        d_addr = 32'hFC;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (d_valid) begin
                pulses++;
                chk("drop_d_rdata", d_rdata, 32'hC0DE0003);
            end
            if (m_req) chk("drop_addr_stable", m_addr, 32'h0C);
        end
        chk("drop_pulses", 32'(pulses), 1);
        chk1("drop_mreq_idle", m_req, 0);
        chk("drop_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Randomized traffic against a transaction-level model
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fix_lat = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        mbusy = 0; mown = FETCH;
        e_addr = '0; e_wdata = '0; e_we = 0;
        e_mreq = 0; e_iv = 0; e_dv = 0; e_ird = '0; e_drd = '0;
        mstarve = 0; iw = 0; dw = 0; abort = 0;
        for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
            tick();
            chk1("rnd_mreq", m_req, e_mreq);
            chk1("rnd_i_valid", i_valid, e_iv);
            chk1("rnd_d_valid", d_valid, e_dv);
            chk("rnd_i_rdata", i_rdata, e_ird);
            chk("rnd_d_rdata", d_rdata, e_drd);
            chk1("rnd_i_stall", i_stall, i_req && !e_iv);
            chk1("rnd_d_stall", d_stall, d_req && !e_dv);
            if (e_mreq) begin
                chk("rnd_m_addr", m_addr, e_addr);
                chk1("rnd_m_we", m_we, e_we);
                if (e_we) chk("rnd_m_wdata", m_wdata, e_wdata);
            end

            if (e_iv || !i_req) begin
                i_req = ($urandom % 2) == 1;
                i_addr = rand_addr();
                iw = 0;
            end else begin
                if (mbusy && mown == FETCH && ($urandom % 4) == 0)
                    i_addr = rand_addr();
                iw++;
            end
            if (e_dv || !d_req) begin
                d_req = ($urandom % 2) == 1;
                d_we = ($urandom % 2) == 1;
                d_addr = rand_addr();
                d_wdata = $urandom;
                dw = 0;
            end else begin
                if (mbusy && mown == DATA && ($urandom % 4) == 0) begin
                    d_addr = rand_addr();
                    d_wdata = $urandom;
                end
                dw++;
            end
            if (iw > 100 || dw > 100) begin
                checks++;
                failures++;
                $display("FAIL rnd_progress actual=i%0d/d%0d cycles waiting expected<=100", iw, dw);
                abort = 1;
            end

            e_iv = 0;
            e_dv = 0;
            if (!mbusy) begin
                if (d_req && !(i_req && mstarve == SMAX)) begin
                    mbusy = 1; mown = DATA; e_mreq = 1;
                    e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
                    mstarve = i_req ? ((mstarve < SMAX) ? mstarve + 1 : SMAX) : 0;
                end else if (i_req) begin
                    mbusy = 1; mown = FETCH; e_mreq = 1;
                    e_addr = i_addr; e_we = 0;
                    mstarve = 0;
                end
            end else if (m_ack) begin
                mbusy = 0;
                e_mreq = 0;
                if (mown == FETCH) begin
                    e_iv = 1;
                    e_ird = ref_mem[e_addr[7:2]];
                end else begin
                    e_dv = 1;
                    if (e_we) ref_mem[e_addr[7:2]] = e_wdata;
                    else e_drd = ref_mem[e_addr[7:2]];
                end
            end
        end
        i_req = 0;
        d_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
